mux_tuple_pipe: RTL and testbench

//  N-way mux of {flag:1, data:W} tuples with per-input valid/ready and a registered 2-entry skid output.

---
 rtl/mux_tuple_pipe_pkg.sv | 23 ++
 rtl/mux_tuple_skid.sv | 73 +++++++
 rtl/mux_tuple_pipe.sv | 105 ++++++++++
 tb/tb_mux_tuple_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_tuple_pipe_pkg.sv
// Shared constants and helpers for the tuple mux pipeline.
// Payload layout: {flag, data}. Data sits at the low bits and the flag directly above it.
package mux_tuple_pipe_pkg;

    // Low bit of the data field inside a packed tuple.
    localparam int unsigned DataLsb = 0;

    // Width of one {flag, data} tuple.
    function automatic int unsigned tuple_width(input int unsigned w);
        return 1 + w;
    endfunction

    // Bit position of the flag inside a packed tuple.
    function automatic int unsigned flag_pos(input int unsigned w);
        return w;
    endfunction

    // Low bit of channel k's data field within the flattened per-channel data bus.
    function automatic int unsigned data_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/mux_tuple_skid.sv
// Two-entry skid buffer: a main register that drives the output and a skid register that
// catches one beat when the consumer stalls. Input ready is registered (not skid full), so
// upstream never sees a combinational path from out_ready_i.
module mux_tuple_skid #(
    parameter int unsigned DW = 3
) (
    input  logic          CLK,
    input  logic          ASYNCRESETN,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    logic          main_valid_q, main_valid_d;
    logic [DW-1:0] main_data_q, main_data_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic          accept;
    logic          drain;

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

    // Next-state for both entries; data registers only load, so outputs hold while idle.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        accept       = in_valid_i && !skid_valid_q;
        drain        = main_valid_q && out_ready_i;

        if (drain) begin
            if (skid_valid_q) begin
                // Skid full means no accept this cycle; promote the waiting beat.
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d = in_data_i;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end else begin
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
            end
        end
    end

    // State registers; reset discards both entries.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/mux_tuple_pipe.sv
// N-way mux of {flag, data} tuples with per-channel valid/ready feeding a 2-entry skid output.
// Optional packet lock: define MUX_TUPLE_PIPE_PKT_LOCK_EN to treat the flag as "last" and hold
// the selected channel from the first accepted beat of a packet until its last beat.
module mux_tuple_pipe
    import mux_tuple_pipe_pkg::*;
#(
    parameter  int unsigned N  = 4,
    parameter  int unsigned W  = 2,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic           CLK,
    input  logic           ASYNCRESETN,
    input  logic [SW-1:0]  S,
    input  logic [N-1:0]   I_valid,
    output logic [N-1:0]   I_ready,
    input  logic [N-1:0]   I__0,
    input  logic [N*W-1:0] I__1,
    output logic           O_valid,
    input  logic           O_ready,
    output logic           O__0,
    output logic [W-1:0]   O__1
);

    localparam int unsigned TW      = tuple_width(W);
    localparam int unsigned FlagPos = flag_pos(W);

    logic [SW-1:0] sel_eff;
    logic [N-1:0]  sel_hit;
    logic [TW-1:0] in_payload;
    logic [TW-1:0] out_payload;
    logic          in_valid;
    logic          skid_in_ready;

`ifdef MUX_TUPLE_PIPE_PKT_LOCK_EN
    logic          locked_q, locked_d;
    logic [SW-1:0] lock_sel_q, lock_sel_d;
    logic          accept;

    assign accept  = in_valid && skid_in_ready;
    assign sel_eff = locked_q ? lock_sel_q : S;

    // Lock on a non-last beat while unlocked; unlock when the last beat is accepted.
    always_comb begin
        locked_d   = locked_q;
        lock_sel_d = lock_sel_q;
        if (accept) begin
            if (locked_q) begin
                if (in_payload[FlagPos]) begin
                    locked_d = 1'b0;
                end
            end else if (!in_payload[FlagPos]) begin
                locked_d   = 1'b1;
                lock_sel_d = S;
            end
        end
    end

    // Lock state register.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            locked_q   <= 1'b0;
            lock_sel_q <= '0;
        end else begin
            locked_q   <= locked_d;
            lock_sel_q <= lock_sel_d;
        end
    end
`else
    assign sel_eff = S;
`endif

    // One-hot channel decode and payload mux; an out-of-range select hits nothing.
    always_comb begin
        sel_hit    = '0;
        in_payload = '0;
        for (int k = 0; k < N; k++) begin
            if ({1'b0, sel_eff} == (SW+1)'(k)) begin
                sel_hit[k]                = 1'b1;
                in_payload[FlagPos]       = I__0[k];
                in_payload[DataLsb +: W]  = I__1[data_lsb(k, W) +: W];
            end
        end
    end

    assign in_valid = |(I_valid & sel_hit);
    // Ready is forced low while reset is asserted, independent of the skid state.
    assign I_ready  = sel_hit & {N{skid_in_ready & ASYNCRESETN}};

    mux_tuple_skid #(
        .DW (TW)
    ) u_skid (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .in_valid_i  (in_valid),
        .in_ready_o  (skid_in_ready),
        .in_data_i   (in_payload),
        .out_valid_o (O_valid),
        .out_ready_i (O_ready),
        .out_data_o  (out_payload)
    );

    assign O__0 = out_payload[FlagPos];
    assign O__1 = out_payload[DataLsb +: W];

endmodule

// File: tb/tb_mux_tuple_pipe.sv
// Directed self-checking bench for mux_tuple_pipe (N=4 main instance, N=3 for out-of-range).
module tb_mux_tuple_pipe;

    logic       CLK = 1'b0;
    logic       ASYNCRESETN = 1'b0;
    logic [1:0] S = '0;
    logic [3:0] I_valid = '0;
    logic [3:0] I_ready;
    logic [3:0] I__0 = '0;
    logic [7:0] I__1 = '0;
    logic       O_valid;
    logic       O_ready = 1'b0;
    logic       O__0;
    logic [1:0] O__1;

    logic [1:0] S3 = '0;
    logic [2:0] I_valid3 = '0;
    logic [2:0] I_ready3;
    logic [2:0] I__0_3 = '0;
    logic [5:0] I__1_3 = '0;
    logic       O_valid3;
    logic       O_ready3 = 1'b0;
    logic       O__0_3;
    logic [1:0] O__1_3;

    int checks = 0;
    int fails  = 0;

    mux_tuple_pipe #(.N(4), .W(2)) dut (
        .CLK (CLK), .ASYNCRESETN (ASYNCRESETN), .S (S),
        .I_valid (I_valid), .I_ready (I_ready), .I__0 (I__0), .I__1 (I__1),
        .O_valid (O_valid), .O_ready (O_ready), .O__0 (O__0), .O__1 (O__1)
    );

    mux_tuple_pipe #(.N(3), .W(2)) dut3 (
        .CLK (CLK), .ASYNCRESETN (ASYNCRESETN), .S (S3),
        .I_valid (I_valid3), .I_ready (I_ready3), .I__0 (I__0_3), .I__1 (I__1_3),
        .O_valid (O_valid3), .O_ready (O_ready3), .O__0 (O__0_3), .O__1 (O__1_3)
    );

    always #5 CLK = ~CLK;

    // Drive point: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        tick();
        S = 2'd2; I_valid = 4'b0100; I__1 = 8'b00_11_00_00; I__0 = '0; O_ready = 1'b0;
        #1;
        checks++; if (I_ready !== 4'b0100) begin fails++;
            $display("FAIL rst_pre_ready got %b want 0100", I_ready); end
        tick();
        I_valid = '0;
        #1;
        checks++; if (O_valid !== 1'b1 || O__1 !== 2'd3) begin fails++;
            $display("FAIL rst_pre_out got v=%b d=%0d want v=1 d=3", O_valid, O__1); end
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        checks++; if (O_valid !== 1'b0 || O__1 !== 2'd0 || O__0 !== 1'b0) begin fails++;
            $display("FAIL rst_async got v=%b f=%b d=%0d want 0 0 0", O_valid, O__0, O__1); end
        checks++; if (I_ready !== 4'b0000) begin fails++;
            $display("FAIL rst_ready got %b want 0000", I_ready); end
        tick();
        tick();
        checks++; if (I_ready !== 4'b0000 || O_valid !== 1'b0) begin fails++;
            $display("FAIL rst_hold got r=%b v=%b want 0000 0", I_ready, O_valid); end
        ASYNCRESETN = 1'b1;
        #1;
        checks++; if (I_ready !== 4'b0100 || O_valid !== 1'b0) begin fails++;
            $display("FAIL rst_release got r=%b v=%b want 0100 0", I_ready, O_valid); end
    endtask

    // Tuple {flag,data} = i for i=0..7: data=i[1:0], flag=i[2].
    task automatic test_streaming();
        logic [2:0] t;
        O_ready = 1'b1; S = 2'd2;
        for (int i = 0; i < 8; i++) begin
            tick();
            t = 3'(i);
            I_valid = 4'b0100; I__1 = '0; I__0 = '0;
            I__1[5:4] = t[1:0]; I__0[2] = t[2];
            #1;
            checks++; if (I_ready !== 4'b0100) begin fails++;
                $display("FAIL stream_ready beat %0d got %b want 0100", i, I_ready); end
            if (i > 0) begin
                checks++; if (O_valid !== 1'b1 || {O__0, O__1} !== 3'(i - 1)) begin fails++;
                    $display("FAIL stream_out beat %0d got v=%b t=%0d want v=1 t=%0d",
                             i, O_valid, {O__0, O__1}, i - 1); end
            end
        end
        tick();
        I_valid = '0;
        #1;
        checks++; if (O_valid !== 1'b1 || {O__0, O__1} !== 3'd7) begin fails++;
            $display("FAIL stream_last got v=%b t=%0d want v=1 t=7", O_valid, {O__0, O__1}); end
        tick();
        #1;
        checks++; if (O_valid !== 1'b0 || {O__0, O__1} !== 3'd7) begin fails++;
            $display("FAIL stream_hold got v=%b t=%0d want v=0 t=7", O_valid, {O__0, O__1}); end
    endtask

    task automatic test_backpressure();
        S = 2'd2; I__0 = '0; O_ready = 1'b0;
        // cycle 0
        tick(); I_valid = 4'b0100; I__1 = 8'b00_01_00_00; #1;
        checks++; if (I_ready !== 4'b0100 || O_valid !== 1'b0) begin fails++;
            $display("FAIL bp_c0 got r=%b v=%b want 0100 0", I_ready, O_valid); end
        // cycle 1
        tick(); I__1 = 8'b00_10_00_00; #1;
        checks++; if (I_ready !== 4'b0100 || O_valid !== 1'b1 || O__1 !== 2'd1) begin fails++;
            $display("FAIL bp_c1 got r=%b v=%b d=%0d want 0100 1 1", I_ready, O_valid, O__1); end
        // cycle 2: skid now full
        tick(); I__1 = 8'b00_11_00_00; #1;
        checks++; if (I_ready !== 4'b0000 || O__1 !== 2'd1) begin fails++;
            $display("FAIL bp_c2 got r=%b d=%0d want 0000 1", I_ready, O__1); end
        // cycle 3: release
        tick(); O_ready = 1'b1; #1;
        checks++; if (I_ready !== 4'b0000 || O_valid !== 1'b1 || O__1 !== 2'd1) begin fails++;
            $display("FAIL bp_c3 got r=%b v=%b d=%0d want 0000 1 1", I_ready, O_valid, O__1); end
        // cycle 4: ready reopens, accept 3 while draining 2
        tick(); #1;
        checks++; if (I_ready !== 4'b0100 || O_valid !== 1'b1 || O__1 !== 2'd2) begin fails++;
            $display("FAIL bp_c4 got r=%b v=%b d=%0d want 0100 1 2", I_ready, O_valid, O__1); end
        tick(); I_valid = '0; #1;
        checks++; if (O_valid !== 1'b1 || O__1 !== 2'd3) begin fails++;
            $display("FAIL bp_c5 got v=%b d=%0d want 1 3", O_valid, O__1); end
        tick(); #1;
        checks++; if (O_valid !== 1'b0) begin fails++;
            $display("FAIL bp_c6 got v=%b want 0", O_valid); end
        O_ready = 1'b0;
    endtask

    task automatic test_out_of_range();
        tick(); S3 = 2'd1; I_valid3 = 3'b010; I__1_3 = 6'b00_10_00; O_ready3 = 1'b0; #1;
        checks++; if (I_ready3 !== 3'b010) begin fails++;
            $display("FAIL oor_inrange got %b want 010", I_ready3); end
        tick(); S3 = 2'd3; I_valid3 = 3'b111; I__1_3 = 6'b11_11_11; I__0_3 = 3'b111; #1;
        checks++; if (I_ready3 !== 3'b000 || O_valid3 !== 1'b1 || O__1_3 !== 2'd2) begin fails++;
            $display("FAIL oor_sel got r=%b v=%b d=%0d want 000 1 2", I_ready3, O_valid3, O__1_3); end
        tick(); O_ready3 = 1'b1; #1;
        checks++; if (O_valid3 !== 1'b1 || O__1_3 !== 2'd2 || I_ready3 !== 3'b000) begin fails++;
            $display("FAIL oor_hold got r=%b v=%b d=%0d want 000 1 2", I_ready3, O_valid3, O__1_3); end
        tick(); #1;
        checks++; if (O_valid3 !== 1'b0) begin fails++;
            $display("FAIL oor_drain got v=%b want 0", O_valid3); end
        tick(); #1;
        checks++; if (O_valid3 !== 1'b0 || O__1_3 !== 2'd2) begin fails++;
            $display("FAIL oor_noacc got v=%b d=%0d want 0 2", O_valid3, O__1_3); end
        I_valid3 = '0; O_ready3 = 1'b0;
    endtask

    task automatic test_switch();
        logic [2:0] exp_prev;
        logic [1:0] d;
        logic       f1;
`ifdef MUX_TUPLE_PIPE_PKT_LOCK_EN
        f1 = 1'b1;
`else
        f1 = 1'b0;
`endif
        exp_prev = '0;
        O_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            d = 2'(i);
            S = 2'(i % 2);
            I_valid = 4'b0011;
            I__1 = '0; I__1[1:0] = d; I__1[3:2] = ~d;
            I__0 = '0; I__0[0] = 1'b1; I__0[1] = f1;
            #1;
            checks++; if (I_ready !== ((i % 2 == 0) ? 4'b0001 : 4'b0010)) begin fails++;
                $display("FAIL switch_ready cyc %0d got %b", i, I_ready); end
            if (i > 0) begin
                checks++; if (O_valid !== 1'b1 || {O__0, O__1} !== exp_prev) begin fails++;
                    $display("FAIL switch_out cyc %0d got v=%b t=%0d want v=1 t=%0d",
                             i, O_valid, {O__0, O__1}, exp_prev); end
            end
            exp_prev = (i % 2 == 0) ? {1'b1, d} : {f1, ~d};
        end
        tick(); I_valid = '0; #1;
        checks++; if (O_valid !== 1'b1 || {O__0, O__1} !== exp_prev) begin fails++;
            $display("FAIL switch_last got v=%b t=%0d want v=1 t=%0d",
                     O_valid, {O__0, O__1}, exp_prev); end
        tick();
    endtask

`ifdef MUX_TUPLE_PIPE_PKT_LOCK_EN
    task automatic test_lock();
        O_ready = 1'b1;
        // beat 1 on ch1 (flag 0); ch0 holds {1,0}
        tick(); S = 2'd1; I_valid = 4'b0011; I__1 = 8'b00_00_01_00; I__0 = 4'b0001; #1;
        checks++; if (I_ready !== 4'b0010) begin fails++;
            $display("FAIL lock_b1 got %b want 0010", I_ready); end
        tick(); S = 2'd0; I__1 = 8'b00_00_10_00; I__0 = 4'b0001; #1;
        checks++; if (I_ready !== 4'b0010 || {O__0, O__1} !== 3'b001) begin fails++;
            $display("FAIL lock_b2 got r=%b t=%0d want 0010 1", I_ready, {O__0, O__1}); end
        tick(); I__1 = 8'b00_00_11_00; I__0 = 4'b0011; #1;
        checks++; if (I_ready !== 4'b0010 || {O__0, O__1} !== 3'b010) begin fails++;
            $display("FAIL lock_b3 got r=%b t=%0d want 0010 2", I_ready, {O__0, O__1}); end
        tick(); I__1 = 8'b00_00_01_00; I__0 = 4'b0001; #1;
        checks++; if (I_ready !== 4'b0001 || {O__0, O__1} !== 3'b111) begin fails++;
            $display("FAIL lock_unlock got r=%b t=%0d want 0001 7", I_ready, {O__0, O__1}); end
        tick(); I_valid = '0; #1;
        checks++; if (O_valid !== 1'b1 || {O__0, O__1} !== 3'b100) begin fails++;
            $display("FAIL lock_next got v=%b t=%0d want 1 4", O_valid, {O__0, O__1}); end
    endtask
`else
    task automatic test_no_lock();
        O_ready = 1'b1;
        tick(); S = 2'd1; I_valid = 4'b0011; I__1 = 8'b00_00_01_00; I__0 = 4'b0001; #1;
        checks++; if (I_ready !== 4'b0010) begin fails++;
            $display("FAIL nolock_b1 got %b want 0010", I_ready); end
        tick(); S = 2'd0; #1;
        checks++; if (I_ready !== 4'b0001 || {O__0, O__1} !== 3'b001) begin fails++;
            $display("FAIL nolock_sw got r=%b t=%0d want 0001 1", I_ready, {O__0, O__1}); end
        tick(); I_valid = '0; #1;
        checks++; if (O_valid !== 1'b1 || {O__0, O__1} !== 3'b100) begin fails++;
            $display("FAIL nolock_next got v=%b t=%0d want 1 4", O_valid, {O__0, O__1}); end
    endtask
`endif

    initial begin
        tick();
        tick();
        ASYNCRESETN = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_out_of_range();
        test_switch();
`ifdef MUX_TUPLE_PIPE_PKT_LOCK_EN
        test_lock();
`else
        test_no_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
